// File: rtl/viterbi_ctrl_pkg.sv
// ============================================================================
// viterbi_ctrl_pkg : shared types and constants for the Viterbi link sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package viterbi_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_PER   = 2'd1,
    ERR_BURST = 2'd2,
    ERR_ONE   = 2'd3
  } err_mode_t;

  localparam logic [1:0] c_MASK_DEFAULT = 2'b01;

endpackage

`default_nettype wire

// File: rtl/chan_err_sched.sv
// ============================================================================
// chan_err_sched : per-symbol channel bit-flip scheduler and injection counter
// Rev 1.0
// ============================================================================
`default_nettype none

module chan_err_sched
  import viterbi_ctrl_pkg::*;
#(
  parameter int PER_W = 3,
  parameter int FRAME = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [1:0]       i_mode,
  input  logic [1:0]       i_mask,
  input  logic [PER_W-1:0] i_per,
  input  logic             i_step,
  output logic [1:0]       o_flip,
  output logic [7:0]       o_inj_ct
);

  localparam int c_FIDX_W = $clog2(FRAME + 1);
  localparam int c_IDX_W  = (c_FIDX_W > PER_W) ? c_FIDX_W : PER_W;
  localparam logic [PER_W-1:0] c_ONE = PER_W'(1);
  localparam logic [PER_W-1:0] c_TWO = PER_W'(2);

  err_mode_t          r_mode;
  logic [1:0]         r_mask;
  logic [PER_W-1:0]   r_per;
  logic [PER_W-1:0]   r_mod;
  logic [c_IDX_W-1:0] r_idx;
  logic [1:0]         r_flip;
  logic [7:0]         r_inj;
  logic               w_hit;

  // r_mod tracks j mod p incrementally so no divider is needed
  always_comb begin
    w_hit = 1'b0;
    case (r_mode)
      ERR_PER:   w_hit = (r_per != '0) && (r_mod == r_per - c_ONE);
      ERR_BURST: w_hit = (r_per != '0) &&
                         ((r_per <= c_TWO) || (r_mod == c_ONE) || (r_mod == c_TWO));
      ERR_ONE:   w_hit = (r_idx == c_IDX_W'(r_per));
      default:   w_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= ERR_NONE;
      r_mask <= '0;
      r_per  <= '0;
      r_mod  <= '0;
      r_idx  <= '0;
      r_flip <= '0;
      r_inj  <= '0;
    end else if (i_load) begin
      r_mode <= err_mode_t'(i_mode);
      r_mask <= (i_mask == 2'b00) ? c_MASK_DEFAULT : i_mask;
      r_per  <= i_per;
      r_mod  <= '0;
      r_idx  <= '0;
      r_flip <= '0;
      r_inj  <= '0;
    end else if (i_step) begin
      r_flip <= w_hit ? r_mask : 2'b00;
      if (w_hit && (r_inj != 8'hFF)) begin
        r_inj <= r_inj + 8'd1;
      end
      r_idx <= r_idx + c_IDX_W'(1);
      r_mod <= ((r_per == '0) || (r_mod == r_per - c_ONE)) ? '0 : r_mod + c_ONE;
    end else begin
      r_flip <= '0;
    end
  end

  assign o_flip   = r_flip;
  assign o_inj_ct = r_inj;

endmodule

`default_nettype wire

// File: rtl/viterbi_link_ctrl.sv
// ============================================================================
// viterbi_link_ctrl : frame sequencer for encoder / channel / Viterbi test link
// Rev 1.0
// ============================================================================
`default_nettype none

module viterbi_link_ctrl
  import viterbi_ctrl_pkg::*;
#(
  parameter int MSG_W   = 8,
  parameter int TAIL    = 2,
  parameter int DEC_LAT = 4,
  parameter int PER_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [MSG_W-1:0]           msg_i,
  input  logic [1:0]                 err_mode_i,
  input  logic [1:0]                 err_mask_i,
  input  logic [PER_W-1:0]           err_per_i,
  input  logic                       dec_bit_i,
  output logic                       enc_bit_o,
  output logic                       enc_en_o,
  output logic [1:0]                 chan_flip_o,
  output logic                       dec_en_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [MSG_W-1:0]           rx_msg_o,
  output logic [$clog2(MSG_W+1)-1:0] bit_err_ct_o,
  output logic [7:0]                 inj_ct_o
);

  localparam int c_N     = MSG_W + TAIL;
  localparam int c_CNT_W = $clog2(c_N + 1);
  localparam int c_ERR_W = $clog2(MSG_W + 1);

  state_t             r_state;
  logic [MSG_W-1:0]   r_msg;
  logic [MSG_W-1:0]   r_tx;
  logic [MSG_W-1:0]   r_rx_shift;
  logic [MSG_W-1:0]   r_rx_msg;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic [c_CNT_W-1:0] r_cap_cnt;
  logic               r_enc_en;
  logic               r_enc_bit;
  logic               r_enc_en_d;
  logic               r_dec_en;
  logic [DEC_LAT-1:0] r_cap_pipe;
  logic               r_busy;
  logic               r_done;
  logic [c_ERR_W-1:0] r_bit_err;
  logic [7:0]         r_inj_ct;
  logic               w_start;
  logic               w_cap;
  logic [7:0]         w_sched_inj;
  logic [c_ERR_W-1:0] w_popcnt;

  assign w_start = (r_state == IDLE) && start_i;
  assign w_cap   = r_cap_pipe[DEC_LAT-1];

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < MSG_W; i++) begin
      w_popcnt = w_popcnt + c_ERR_W'(r_rx_shift[i] ^ r_msg[i]);
    end
  end

  chan_err_sched #(
    .PER_W (PER_W),
    .FRAME (c_N)
  ) u_sched (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_start),
    .i_mode   (err_mode_i),
    .i_mask   (err_mask_i),
    .i_per    (err_per_i),
    .i_step   (r_enc_en),
    .o_flip   (chan_flip_o),
    .o_inj_ct (w_sched_inj)
  );

  // Channel register then decoder: the capture enable trails dec_en by DEC_LAT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enc_en_d <= 1'b0;
      r_dec_en   <= 1'b0;
      r_cap_pipe <= '0;
    end else begin
      r_enc_en_d    <= r_enc_en;
      r_dec_en      <= r_enc_en_d;
      r_cap_pipe[0] <= r_dec_en;
      for (int i = 1; i < DEC_LAT; i++) begin
        r_cap_pipe[i] <= r_cap_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_msg      <= '0;
      r_tx       <= '0;
      r_rx_shift <= '0;
      r_rx_msg   <= '0;
      r_bit_cnt  <= '0;
      r_cap_cnt  <= '0;
      r_enc_en   <= 1'b0;
      r_enc_bit  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bit_err  <= '0;
      r_inj_ct   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state    <= SEND;
            r_busy     <= 1'b1;
            r_msg      <= msg_i;
            r_tx       <= {msg_i[MSG_W-2:0], 1'b0};
            r_enc_en   <= 1'b1;
            r_enc_bit  <= msg_i[MSG_W-1];
            r_bit_cnt  <= c_CNT_W'(1);
            r_cap_cnt  <= '0;
            r_rx_shift <= '0;
            r_rx_msg   <= '0;
            r_bit_err  <= '0;
            r_inj_ct   <= '0;
          end
        end
        SEND: begin
          if (r_bit_cnt == c_CNT_W'(c_N)) begin
            r_enc_en  <= 1'b0;
            r_enc_bit <= 1'b0;
            r_state   <= DRAIN;
          end else begin
            // r_tx empties to zero after MSG_W shifts, giving the flush bits
            r_enc_bit <= r_tx[MSG_W-1];
            r_tx      <= {r_tx[MSG_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
          end
        end
        DRAIN: begin
          if (w_cap && (r_cap_cnt == c_CNT_W'(c_N - 1))) begin
            r_state <= REPORT;
          end
        end
        REPORT: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_rx_msg  <= r_rx_shift;
          r_bit_err <= w_popcnt;
          r_inj_ct  <= w_sched_inj;
        end
        default: r_state <= IDLE;
      endcase

      if (w_cap) begin
        r_cap_cnt <= r_cap_cnt + c_CNT_W'(1);
        if (r_cap_cnt < c_CNT_W'(MSG_W)) begin
          r_rx_shift <= {r_rx_shift[MSG_W-2:0], dec_bit_i};
        end
      end
    end
  end

  assign enc_bit_o    = r_enc_bit;
  assign enc_en_o     = r_enc_en;
  assign dec_en_o     = r_dec_en;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign rx_msg_o     = r_rx_msg;
  assign bit_err_ct_o = r_bit_err;
  assign inj_ct_o     = r_inj_ct;

endmodule

`default_nettype wire
